if_id_inst_queue: RTL and testbench



---
 rtl/if_id_inst_queue_pkg.sv | 20 ++
 rtl/if_id_inst_queue_iq_ram.sv | 32 +++
 rtl/if_id_inst_queue.sv | 91 +++++++++
 tb/tb_if_id_inst_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_inst_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue.
// Holds the instruction and PC widths, the decoder NOP encoding and the
// packed queue-entry layout {excp, pc, inst} used by the queue and its RAM.
package if_id_inst_queue_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  // Presented on id_inst_o whenever the queue is empty.
  localparam logic [INST_W-1:0] NOP_INST = 32'h0340_0000;

  typedef struct packed {
    logic              excp;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/if_id_inst_queue_iq_ram.sv
// Entry storage for the IF/ID instruction queue: DEPTH x iq_entry_t.
// Synchronous write, asynchronous (combinational) read. Not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   entry written on posedge clk when we=1
//   raddr  in   read slot
//   rdata  out  entry stored at raddr
module if_id_inst_queue_iq_ram
  import if_id_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  iq_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output iq_entry_t        rdata
);

  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_inst_queue.sv
// Instruction queue between fetch (IF) and decode (ID).
// Buffers {pc, inst, excp} entries in strict FIFO order, presents the head
// combinationally to decode, and drops everything on flush_i.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush_i                synchronous clear, overrides push/pop
//   if_valid_i/if_ready_o  fetch handshake; if_pc_i/if_inst_i/if_excp_i entry
//   id_valid_o/id_ready_i  decode handshake; id_pc_o/id_inst_o/id_excp_o head
//   count_o                current occupancy (0..DEPTH)
module if_id_inst_queue
  import if_id_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              if_valid_i,
  input  logic [PC_W-1:0]   if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  input  logic              if_excp_i,
  output logic              if_ready_o,
  output logic              id_valid_o,
  output logic [PC_W-1:0]   id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_excp_o,
  input  logic              id_ready_i,
  output logic [PTR_W:0]    count_o
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;
  iq_entry_t        wr_entry, head;

  // Handshakes depend only on occupancy: no pass-through when full,
  // no bypass when empty, and flush does not gate them.
  assign if_ready_o = (count != DEPTH_C);
  assign id_valid_o = (count != '0);
  assign push       = if_valid_i & if_ready_o;
  assign pop        = id_valid_o & id_ready_i;

  assign wr_entry = '{excp: if_excp_i, pc: if_pc_i, inst: if_inst_i};

  if_id_inst_queue_iq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_iq_ram (
    .clk   (clk),
    .we    (push & ~flush_i),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  // Empty queue shows a clean NOP so decode never sees stale storage.
  always_comb begin
    id_pc_o   = '0;
    id_inst_o = NOP_INST;
    id_excp_o = 1'b0;
    if (id_valid_o) begin
      id_pc_o   = head.pc;
      id_inst_o = head.inst;
      id_excp_o = head.excp;
    end
  end

  assign count_o = count;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C)
    else $error("queue occupancy out of range: %0d", count);

endmodule

// File: tb/tb_if_id_inst_queue.sv
module tb_if_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic [31:0] if_inst_i = '0;
  logic        if_excp_i = 1'b0;
  logic        if_ready_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_excp_o;
  logic        id_ready_i = 1'b0;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0340_0000;

  if_id_inst_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .if_pc_i    (if_pc_i),
    .if_inst_i  (if_inst_i),
    .if_excp_i  (if_excp_i),
    .if_ready_o (if_ready_o),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_excp_o  (id_excp_o),
    .id_ready_i (id_ready_i),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic excp);
    if_valid_i = v;
    if_pc_i    = pc;
    if_inst_i  = inst;
    if_excp_i  = excp;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, 32'(id_valid_o), 32'd0);
    check({tag, ".count"}, 32'(count_o), 32'd0);
    check({tag, ".inst"},  id_inst_o, NOP);
    check({tag, ".pc"},    id_pc_o, 32'd0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic excp);
    check({tag, ".valid"}, 32'(id_valid_o), 32'd1);
    check({tag, ".pc"},    id_pc_o, pc);
    check({tag, ".inst"},  id_inst_o, inst);
    check({tag, ".excp"},  32'(id_excp_o), 32'(excp));
  endtask

  initial begin
    // T1: reset held for 3 cycles
    repeat (3) tick();
    check_empty("t1");
    check("t1.ready", 32'(if_ready_o), 32'd1);
    check("t1.excp", 32'(id_excp_o), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // T2: fill with decode stalled, drop a 5th push, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1c00_0000 + 32'(4*i), 32'h0280_0421 + 32'(i), 1'b0);
      tick();
    end
    check("t2.count_full", 32'(count_o), 32'd4);
    check("t2.ready_full", 32'(if_ready_o), 32'd0);
    drive(1'b1, 32'h1c00_0010, 32'hdead_beef, 1'b0);
    tick();
    check("t2.count_5th", 32'(count_o), 32'd4);
    drive(1'b0, '0, '0, 1'b0);
    id_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("t2.out%0d", i), 32'h1c00_0000 + 32'(4*i),
                 32'h0280_0421 + 32'(i), 1'b0);
      tick();
    end
    id_ready_i = 1'b0;
    check_empty("t2.drained");

    // T3: steady push+pop at count=2, 12 entries through a 4-deep queue
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h1c00_1000 + 32'(4*k), 32'h0000_0100 + 32'(k), 1'b0);
      tick();
    end
    check("t3.count_pre", 32'(count_o), 32'd2);
    id_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 32'h1c00_1000 + 32'(4*(c+2)), 32'h0000_0100 + 32'(c+2), 1'b0);
      check_head($sformatf("t3.out%0d", c), 32'h1c00_1000 + 32'(4*c),
                 32'h0000_0100 + 32'(c), 1'b0);
      tick();
      check($sformatf("t3.count%0d", c), 32'(count_o), 32'd2);
    end
    drive(1'b0, '0, '0, 1'b0);
    for (int c = 10; c < 12; c++) begin
      check_head($sformatf("t3.tail%0d", c), 32'h1c00_1000 + 32'(4*c),
                 32'h0000_0100 + 32'(c), 1'b0);
      tick();
    end
    id_ready_i = 1'b0;
    check_empty("t3.drained");

    // T4: flush at count=3 with a colliding push
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1c00_2000 + 32'(4*k), 32'h0000_0200 + 32'(k), 1'b0);
      tick();
    end
    check("t4.count_pre", 32'(count_o), 32'd3);
    drive(1'b1, 32'h0000_0bad, 32'h0bad_0bad, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b1, 32'h1c00_3000, 32'h0000_0300, 1'b0);
    check_empty("t4.flushed");
    check("t4.ready", 32'(if_ready_o), 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check_head("t4.next", 32'h1c00_3000, 32'h0000_0300, 1'b0);
    check("t4.count_next", 32'(count_o), 32'd1);
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    check_empty("t4.after");

    // T5: exception flag travels with its entry
    drive(1'b1, 32'h1c00_0003, 32'h0000_0500, 1'b1);
    tick();
    drive(1'b1, 32'h1c00_0008, 32'h0000_0501, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check_head("t5.excp_entry", 32'h1c00_0003, 32'h0000_0500, 1'b1);
    id_ready_i = 1'b1;
    tick();
    check_head("t5.next_entry", 32'h1c00_0008, 32'h0000_0501, 1'b0);
    tick();
    id_ready_i = 1'b0;
    check_empty("t5.drained");

    // T6: async reset between edges with count=3
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1c00_4000 + 32'(4*k), 32'h0000_0600 + 32'(k), 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("t6.count_pre", 32'(count_o), 32'd3);
    check("t6.valid_pre", 32'(id_valid_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_empty("t6.in_reset");
    check("t6.ready", 32'(if_ready_o), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    check_empty("t6.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
